io_input_ctrl: RTL and testbench

- Memory-mapped input peripheral for the push-buttons (KEY) and slide switches (SW).
- Sits between the raw board pins and the data-memory read path. The processor's load/store stage drives it with the ALU address, store data and enables.
- Synchronises and debounces each input bit, and exposes a debounced-state register and a sticky status register per device.
- Gives software edge notification without polling raw, bouncing pins.

---
 rtl/io_pkg.sv | 73 +++++++
 rtl/debounce_bit.sv | 77 +++++++
 rtl/io_input_ctrl.sv | 154 +++++++++++++++
 tb/tb_io_input_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the memory-mapped KEY/SW input peripheral:
//   - register addresses of the four mapped words
//   - status word bit positions (READY, OVERRUN)
//   - default debounce qualification length
//   - status record type and helpers that compute its next value and its
//     software-visible encoding
// No ports (package).
// -----------------------------------------------------------------------------
package io_pkg;

   localparam logic [31:0] IO_ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] IO_ADDR_SDATA = 32'hF000_0014;
   localparam logic [31:0] IO_ADDR_KCTRL = 32'hF000_0110;
   localparam logic [31:0] IO_ADDR_SCTRL = 32'hF000_0114;

   localparam int READY_BIT = 0;
   localparam int OVR_BIT   = 2;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

   // Per-device sticky status.
   typedef struct packed {
      logic ovr;
      logic ready;
   } status_t;

   // Next status value. An incoming event always wins over a clear in the
   // same cycle; a read-clear coinciding with an event suppresses the
   // overrun because software has consumed the previous event.
   function automatic status_t status_next(
      input status_t cur,
      input logic    evt,
      input logic    rd_clr,
      input logic    wr_clr
   );
      status_t nxt;
      nxt = cur;
      if (evt) begin
         nxt.ready = 1'b1;
         if (cur.ready && !rd_clr) begin
            nxt.ovr = 1'b1;
         end else if (wr_clr) begin
            nxt.ovr = 1'b0;
         end else begin
            nxt.ovr = cur.ovr;
         end
      end else begin
         if (rd_clr) begin
            nxt.ready = 1'b0;
         end else begin
            nxt.ready = cur.ready;
         end
         if (wr_clr) begin
            nxt.ovr = 1'b0;
         end else begin
            nxt.ovr = cur.ovr;
         end
      end
      return nxt;
   endfunction

   // Software view of the status record; unused bits read as zero.
   function automatic logic [31:0] status_word(input status_t st);
      logic [31:0] w;
      w            = 32'h0000_0000;
      w[READY_BIT] = st.ready;
      w[OVR_BIT]   = st.ovr;
      return w;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// Two-flop synchronizer followed by a consecutive-cycle qualifier for one
// raw input bit. The debounced value only follows the synchronized input
// once it has differed for DEBOUNCE_CYCLES consecutive samples; any sample
// agreeing with the current debounced value restarts the qualification.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   raw     - asynchronous input bit
//   stable  - debounced value
//   changed - single-cycle pulse, high in the cycle whose clock edge
//             updates stable
// -----------------------------------------------------------------------------
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = io_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic changed
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Synchronizer flops for the asynchronous pin.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Qualification counter and debounced value next-state.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1'b1);
      end
   end

   // Counter and debounced value state.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

   // Pulse aligned with the edge that updates stable_q, so status logic in
   // the parent sees the event on the same edge the data register changes.
   assign changed = (stable_d != stable_q) && !reset;

endmodule

// File: rtl/io_input_ctrl.sv
// -----------------------------------------------------------------------------
// io_input_ctrl
// Memory-mapped input peripheral for push-buttons (KEY, active-low) and
// slide switches (SW). Every bit is synchronized and debounced; software
// sees the debounced vectors plus a sticky READY/OVERRUN status word per
// device, so it can detect changes without polling bouncing pins.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   addr   - byte address from the ALU
//   rdEn   - load in progress (gates the READY clear side effect only)
//   wrEn   - store in progress
//   wrData - store data (bit OVR_BIT written 0 clears OVERRUN)
//   KEY    - raw buttons, active-low
//   SW     - raw switches
//   rdData - combinational read data for addr
//   hit    - addr selects one of the four mapped registers
// -----------------------------------------------------------------------------
module io_input_ctrl
   import io_pkg::*;
#(
   parameter int               DBITS           = 32,
   parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int               KEY_BITS        = 4,
   parameter int               SW_BITS         = 10,
   parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(IO_ADDR_KDATA),
   parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(IO_ADDR_SDATA),
   parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(IO_ADDR_KCTRL),
   parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(IO_ADDR_SCTRL)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DBITS-1:0]    addr,
   input  logic                rdEn,
   input  logic                wrEn,
   input  logic [DBITS-1:0]    wrData,
   input  logic [KEY_BITS-1:0] KEY,
   input  logic [SW_BITS-1:0]  SW,
   output logic [DBITS-1:0]    rdData,
   output logic                hit
);

   logic [KEY_BITS-1:0] key_pressed_s;
   logic [KEY_BITS-1:0] key_stable_s;
   logic [KEY_BITS-1:0] key_chg_s;
   logic [SW_BITS-1:0]  sw_stable_s;
   logic [SW_BITS-1:0]  sw_chg_s;

   logic    key_evt_s;
   logic    sw_evt_s;
   logic    sel_kdata_s;
   logic    sel_sdata_s;
   logic    sel_kctrl_s;
   logic    sel_sctrl_s;
   logic    key_rd_clr_s;
   logic    sw_rd_clr_s;
   logic    key_wr_clr_s;
   logic    sw_wr_clr_s;
   status_t key_st_q;
   status_t key_st_d;
   status_t sw_st_q;
   status_t sw_st_d;
   logic    unused_wr_s;

   // Inversion is a per-bit NOT, so it commutes with the synchronizer
   // flops. Applying it at the synchronizer input keeps the flops' reset
   // value of 0 meaning "released" and avoids a spurious press being
   // qualified right after reset.
   assign key_pressed_s = ~KEY;

   for (genvar gi = 0; gi < KEY_BITS; gi++) begin : g_key
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk),
         .reset   (reset),
         .raw     (key_pressed_s[gi]),
         .stable  (key_stable_s[gi]),
         .changed (key_chg_s[gi])
      );
   end

   for (genvar gi = 0; gi < SW_BITS; gi++) begin : g_sw
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk),
         .reset   (reset),
         .raw     (SW[gi]),
         .stable  (sw_stable_s[gi]),
         .changed (sw_chg_s[gi])
      );
   end

   // Several bits changing together count as one device event.
   assign key_evt_s = |key_chg_s;
   assign sw_evt_s  = |sw_chg_s;

   assign sel_kdata_s = (addr == ADDR_KDATA);
   assign sel_sdata_s = (addr == ADDR_SDATA);
   assign sel_kctrl_s = (addr == ADDR_KCTRL);
   assign sel_sctrl_s = (addr == ADDR_SCTRL);

   // Loading a DATA word acknowledges that device's event.
   assign key_rd_clr_s = rdEn && sel_kdata_s;
   assign sw_rd_clr_s  = rdEn && sel_sdata_s;

   // Only a zero in the OVERRUN position clears it; READY is not writable.
   assign key_wr_clr_s = wrEn && sel_kctrl_s && !wrData[OVR_BIT];
   assign sw_wr_clr_s  = wrEn && sel_sctrl_s && !wrData[OVR_BIT];

   // Only the OVERRUN bit of the store data is meaningful.
   assign unused_wr_s = ^{wrData[DBITS-1:OVR_BIT+1], wrData[OVR_BIT-1:0]};

   // Status next-state for both devices.
   always_comb begin
      key_st_d = status_next(key_st_q, key_evt_s, key_rd_clr_s, key_wr_clr_s);
      sw_st_d  = status_next(sw_st_q, sw_evt_s, sw_rd_clr_s, sw_wr_clr_s);
   end

   // Sticky status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_st_q <= '0;
         sw_st_q  <= '0;
      end else begin
         key_st_q <= key_st_d;
         sw_st_q  <= sw_st_d;
      end
   end

   // Zero-latency read mux; rdEn deliberately plays no part here.
   always_comb begin
      rdData = '0;
      hit    = 1'b0;
      if (sel_kdata_s) begin
         rdData = DBITS'(key_stable_s);
         hit    = 1'b1;
      end else if (sel_sdata_s) begin
         rdData = DBITS'(sw_stable_s);
         hit    = 1'b1;
      end else if (sel_kctrl_s) begin
         rdData = DBITS'(status_word(key_st_q));
         hit    = 1'b1;
      end else if (sel_sctrl_s) begin
         rdData = DBITS'(status_word(sw_st_q));
         hit    = 1'b1;
      end else begin
         rdData = '0;
         hit    = 1'b0;
      end
   end

endmodule

// File: tb/tb_io_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_input_ctrl
// Self-checking bench for io_input_ctrl with DEBOUNCE_CYCLES=4. A reference
// model tracks, per bit, a two-edge input delay and a window of the last
// DB synchronized samples: a debounced bit flips when the whole window
// disagrees with it. Status follows the READY/OVERRUN rules as boolean
// equations. Directed scenarios check fixed values; a random phase
// compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_io_input_ctrl;

   localparam int DB = 4;
   localparam int KB = 4;
   localparam int SB = 10;
   localparam int NB = KB + SB;

   localparam logic [31:0] A_KD = 32'hF000_0010;
   localparam logic [31:0] A_SD = 32'hF000_0014;
   localparam logic [31:0] A_KC = 32'hF000_0110;
   localparam logic [31:0] A_SC = 32'hF000_0114;
   localparam logic [31:0] A_NO = 32'hF000_0018;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        rdEn;
   logic        wrEn;
   logic [31:0] wrData;
   logic [3:0]  KEY;
   logic [9:0]  SW;
   logic [31:0] rdData;
   logic        hit;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // model state
   bit          m_d1     [NB];
   bit          m_d2     [NB];
   bit [DB-1:0] m_win    [NB];
   bit          m_stable [NB];
   bit          m_rdy    [2];
   bit          m_ovr    [2];

   io_input_ctrl #(
      .DBITS           (32),
      .DEBOUNCE_CYCLES (DB),
      .KEY_BITS        (KB),
      .SW_BITS         (SB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .rdEn   (rdEn),
      .wrEn   (wrEn),
      .wrData (wrData),
      .KEY    (KEY),
      .SW     (SW),
      .rdData (rdData),
      .hit    (hit)
   );

   always #5 clk = ~clk;

   function automatic void model_edge();
      bit raw;
      bit synced;
      bit evt [2];
      bit rdclr [2];
      bit wrclr [2];
      int dev;
      if (reset) begin
         for (int b = 0; b < NB; b++) begin
            m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_win[b] = '0; m_stable[b] = 1'b0;
         end
         for (int d = 0; d < 2; d++) begin
            m_rdy[d] = 1'b0; m_ovr[d] = 1'b0;
         end
         return;
      end
      evt[0] = 1'b0; evt[1] = 1'b0;
      for (int b = 0; b < NB; b++) begin
         raw    = (b < KB) ? ~KEY[b] : SW[b-KB];
         synced = m_d2[b];
         m_d2[b] = m_d1[b];
         m_d1[b] = raw;
         m_win[b] = {m_win[b][DB-2:0], synced};
         if (m_win[b] == {DB{~m_stable[b]}}) begin
            m_stable[b] = ~m_stable[b];
            dev = (b < KB) ? 0 : 1;
            evt[dev] = 1'b1;
         end
      end
      rdclr[0] = rdEn && (addr == A_KD);
      rdclr[1] = rdEn && (addr == A_SD);
      wrclr[0] = wrEn && (addr == A_KC) && !wrData[2];
      wrclr[1] = wrEn && (addr == A_SC) && !wrData[2];
      for (int d = 0; d < 2; d++) begin
         m_ovr[d] = (evt[d] && m_rdy[d] && !rdclr[d]) || (m_ovr[d] && !wrclr[d]);
         m_rdy[d] = evt[d] || (m_rdy[d] && !rdclr[d]);
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (a == A_KD) begin
         for (int b = 0; b < KB; b++) v[b] = m_stable[b];
      end else if (a == A_SD) begin
         for (int b = 0; b < SB; b++) v[b] = m_stable[KB+b];
      end else if (a == A_KC) begin
         v = {29'd0, m_ovr[0], 1'b0, m_rdy[0]};
      end else if (a == A_SC) begin
         v = {29'd0, m_ovr[1], 1'b0, m_rdy[1]};
      end else begin
         v = 32'h0;
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      logic [31:0] addrs [4];
      addrs = '{A_KD, A_SD, A_KC, A_SC};
      reset = 1'b1; KEY = 4'hF; SW = 10'h000; rdEn = 1'b0; wrEn = 1'b0;
      addr = A_KD; wrData = 32'h0;
      ticks(3);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         addr = addrs[i];
         #1;
         total_cnt++;
         if (rdData !== 32'h0) $display("FAIL reset_rd[%0d]: got %h want %h", i, rdData, 32'h0);
         else pass_cnt++;
         total_cnt++;
         if (hit !== 1'b1) $display("FAIL reset_hit[%0d]: got %b want 1", i, hit);
         else pass_cnt++;
      end
   endtask

   task automatic test_key_press();
      KEY = 4'hE;
      ticks(5);
      addr = A_KD; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL key_early: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
      tick();
      addr = A_KD; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL key_kdata6: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      addr = A_KC; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL key_kctrl6: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      addr = A_KD; rdEn = 1'b1;
      tick();
      rdEn = 1'b0; addr = A_KC; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL key_rdclr: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
      KEY = 4'hF;
      ticks(8);
      addr = A_KD; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL key_release: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_bounce();
      bit pat [5];
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         SW[3] = pat[i];
         if (i < 4) tick();
      end
      for (int i = 1; i <= 6; i++) begin
         tick();
         addr = A_SD; #1;
         total_cnt++;
         if (rdData !== ((i == 6) ? 32'h8 : 32'h0))
            $display("FAIL bounce_sdata_c%0d: got %h want %h", i, rdData, (i == 6) ? 32'h8 : 32'h0);
         else pass_cnt++;
      end
      ticks(3);
      addr = A_SC; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL bounce_sctrl: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
   endtask

   task automatic test_overrun();
      addr = A_SD; rdEn = 1'b1; tick(); rdEn = 1'b0;
      SW[0] = 1'b1; ticks(7);
      SW[0] = 1'b0; ticks(7);
      addr = A_SC; #1;
      total_cnt++;
      if (rdData !== 32'h5) $display("FAIL ovr_two_evt: got %h want %h", rdData, 32'h5);
      else pass_cnt++;
      addr = A_SC; wrEn = 1'b1; wrData = 32'h0; tick(); wrEn = 1'b0;
      #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL ovr_wrclr: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      addr = A_SD; rdEn = 1'b1; tick(); rdEn = 1'b0;
      addr = A_SC; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL ovr_rdclr: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_collide();
      addr = A_KD; rdEn = 1'b1; tick(); rdEn = 1'b0;
      addr = A_KC; wrEn = 1'b1; wrData = 32'h0; tick(); wrEn = 1'b0;
      KEY = 4'hD; ticks(6);
      addr = A_KC; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL coll_press: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      KEY = 4'hF; ticks(5);
      addr = A_KD; rdEn = 1'b1; tick(); rdEn = 1'b0;
      addr = A_KC; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL coll_kctrl: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      addr = A_KD; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL coll_kdata: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      SW[5] = 1'b1;
      ticks(4);
      reset = 1'b1; tick(); reset = 1'b0;
      addr = A_SD; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL rmid_after: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
      ticks(5);
      addr = A_SD; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL rmid_c5: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
      tick();
      addr = A_SD; #1;
      total_cnt++;
      if (rdData !== 32'h28) $display("FAIL rmid_c6: got %h want %h", rdData, 32'h28);
      else pass_cnt++;
      addr = A_SC; #1;
      total_cnt++;
      if (rdData !== 32'h1) $display("FAIL rmid_sctrl: got %h want %h", rdData, 32'h1);
      else pass_cnt++;
      addr = A_NO; #1;
      total_cnt++;
      if (rdData !== 32'h0) $display("FAIL unmapped_rd: got %h want %h", rdData, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (hit !== 1'b0) $display("FAIL unmapped_hit: got %b want 0", hit);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] addrs [5];
      int          bitsel;
      int          errs;
      logic [31:0] exp_v;
      logic        exp_h;
      addrs = '{A_KD, A_SD, A_KC, A_SC, A_NO};
      errs  = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(7, 0) == 0) begin
            bitsel = $urandom_range(NB - 1, 0);
            if (bitsel < KB) KEY[bitsel] = ~KEY[bitsel];
            else SW[bitsel-KB] = ~SW[bitsel-KB];
         end
         addr   = addrs[$urandom_range(4, 0)];
         rdEn   = ($urandom_range(3, 0) == 0);
         wrEn   = ($urandom_range(5, 0) == 0);
         wrData = $urandom;
         #1;
         exp_v = model_read(addr);
         exp_h = (addr != A_NO);
         total_cnt++;
         if (rdData !== exp_v || hit !== exp_h) begin
            if (errs < 10) $display("FAIL rand_c%0d addr %h: got %h/%b want %h/%b",
                                    c, addr, rdData, hit, exp_v, exp_h);
            errs++;
         end else pass_cnt++;
         tick();
      end
      rdEn = 1'b0; wrEn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         addr = addrs[i]; #1;
         total_cnt++;
         if (rdData !== model_read(addrs[i]))
            $display("FAIL rand_final[%0d]: got %h want %h", i, rdData, model_read(addrs[i]));
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_key_press();
      test_bounce();
      test_overrun();
      test_collide();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
